// File: rtl/led_fade_pwm.sv
// LED comet-tail stage: lit channels snap to full brightness, released ones fade out via per-channel PWM.
// Optional LED_FADE_GAMMA_EN squares the brightness level for perceptual correction.
module led_fade_pwm #(
    parameter int PWM_BITS  = 8,
    parameter int DECAY_DIV = 52941
) (
    input  logic       sys_clk,
    input  logic       btn_A,
    input  logic [5:0] led_in,
    input  logic       fade_en,
    output logic [5:0] led_out
);

    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = MAX - ONE;
    localparam int                  DW       = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DW-1:0]       DECAY_LAST = DW'(DECAY_DIV - 1);
    localparam logic [DW-1:0]       DECAY_ONE  = DW'(1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DW-1:0]       decay_cnt;
    logic                decay_tick;
    logic [PWM_BITS-1:0] level [6];
    logic [PWM_BITS-1:0] eff   [6];

    assign decay_tick = (decay_cnt == DECAY_LAST);

    // Free-running PWM and decay prescaler; both ignore fade_en.
    always_ff @(posedge sys_clk or negedge btn_A) begin
        if (!btn_A) begin
            pwm_cnt   <= '0;
            decay_cnt <= '0;
        end else begin
            pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + ONE;
            decay_cnt <= decay_tick ? '0 : decay_cnt + DECAY_ONE;
        end
    end

    // A lit input wins over a coincident decay tick; levels saturate at zero.
    always_ff @(posedge sys_clk or negedge btn_A) begin
        if (!btn_A) begin
            for (int i = 0; i < 6; i++) level[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!led_in[i])
                    level[i] <= MAX;
                else if (decay_tick && (level[i] != '0))
                    level[i] <= level[i] - ONE;
            end
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq [6];

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            sq[i]  = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
            eff[i] = (level[i] == MAX) ? MAX : sq[i][2*PWM_BITS-1:PWM_BITS];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 6; i++) eff[i] = level[i];
    end
`endif

    // Active-low pins: on while the effective brightness exceeds the PWM phase.
    always_ff @(posedge sys_clk or negedge btn_A) begin
        if (!btn_A) begin
            led_out <= 6'b111111;
        end else if (fade_en) begin
            for (int i = 0; i < 6; i++) led_out[i] <= ~(eff[i] > pwm_cnt);
        end else begin
            led_out <= led_in;
        end
    end

endmodule
